// File: rtl/rice_pkg.sv
// rice_pkg: shared types and constants for the counter CSR block.
package rice_pkg;
    localparam int RICE_XLEN = 32;
    localparam int RICE_COUNTER_CY = 0;
    localparam int RICE_COUNTER_IR = 1;
    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } rice_privilege_level;
    typedef enum logic [1:0] {
        SEL_MCYCLE    = 2'd0,
        SEL_MINSTRET  = 2'd1,
        SEL_MCYCLEH   = 2'd2,
        SEL_MINSTRETH = 2'd3
    } rice_counter_sel;
    // Reserved privilege 2 matches none of the terms, so it never grants a read.
    function automatic logic read_en(logic [1:0] priv, logic m_en, logic s_en);
        return (priv == PRIV_M) | ((priv == PRIV_S) & m_en) | ((priv == PRIV_U) & m_en & s_en);
    endfunction
endpackage

// File: rtl/rice_csr_counter_ctrl_if.sv
// rice_csr_counter_ctrl_if: control inputs and counter/enable outputs of the counter CSR block.
interface rice_csr_counter_ctrl_if #(parameter int XLEN = 32);
    logic [1:0]      i_privilege_level;
    logic [1:0]      i_mcounteren;
    logic [1:0]      i_scounteren;
    logic [1:0]      i_mcountinhibit;
    logic            i_retire;
    logic            i_counter_write_valid;
    logic [1:0]      i_counter_write_sel;
    logic [XLEN-1:0] i_counter_write_data;
    logic [XLEN-1:0] o_cycle;
    logic [XLEN-1:0] o_cycleh;
    logic [XLEN-1:0] o_instret;
    logic [XLEN-1:0] o_instreth;
    logic            o_cycle_read_enable;
    logic            o_instret_read_enable;
    logic            o_write_enable;
    modport master (
        output i_privilege_level, i_mcounteren, i_scounteren, i_mcountinhibit, i_retire,
               i_counter_write_valid, i_counter_write_sel, i_counter_write_data,
        input  o_cycle, o_cycleh, o_instret, o_instreth, o_cycle_read_enable,
               o_instret_read_enable, o_write_enable
    );
    modport slave (
        input  i_privilege_level, i_mcounteren, i_scounteren, i_mcountinhibit, i_retire,
               i_counter_write_valid, i_counter_write_sel, i_counter_write_data,
        output o_cycle, o_cycleh, o_instret, o_instreth, o_cycle_read_enable,
               o_instret_read_enable, o_write_enable
    );
endinterface

// File: rtl/rice_csr_split_counter.sv
// rice_csr_split_counter: 64-bit counter held as two halves, optionally with a registered low->high carry.
module rice_csr_split_counter #(
    parameter int XLEN        = 32,
    parameter bit SPLIT_CARRY = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_up,
    input  logic            i_write_low,
    input  logic            i_write_high,
    input  logic [XLEN-1:0] i_write_data,
    output logic [XLEN-1:0] o_low,
    output logic [XLEN-1:0] o_high
);
    logic [XLEN-1:0] r_low, r_high, w_low_nxt, w_high_nxt;
    logic            r_carry, w_wrap, w_carry_in;
    // A carry already captured lands in high even when low is rewritten; a high write drops it.
    always_comb begin
        w_wrap     = i_up & ~i_write_low & (r_low == '1);
        w_carry_in = SPLIT_CARRY ? r_carry : w_wrap;
        w_low_nxt  = i_write_low ? i_write_data : r_low + XLEN'(i_up);
        w_high_nxt = i_write_high ? i_write_data : r_high + XLEN'(w_carry_in);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_low   <= '0;
            r_high  <= '0;
            r_carry <= 1'b0;
        end else begin
            r_low   <= w_low_nxt;
            r_high  <= w_high_nxt;
            r_carry <= SPLIT_CARRY & w_wrap;
        end
    end
    assign o_low  = r_low;
    assign o_high = r_high;
endmodule

// File: rtl/rice_csr_counter_ctrl.sv
// rice_csr_counter_ctrl: cycle/instret counters with M-level writes, inhibit and privilege read gating.
module rice_csr_counter_ctrl import rice_pkg::*; #(
    parameter int XLEN        = RICE_XLEN,
    parameter bit SPLIT_CARRY = 1'b1
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    rice_csr_counter_ctrl_if.slave bus
);
    logic       w_cy_up, w_ir_up;
    logic [3:0] w_wr;
    assign w_cy_up = ~bus.i_mcountinhibit[RICE_COUNTER_CY];
    assign w_ir_up = bus.i_retire & ~bus.i_mcountinhibit[RICE_COUNTER_IR];
    // One-hot write strobe indexed by rice_counter_sel.
    assign w_wr = bus.i_counter_write_valid ? (4'b0001 << bus.i_counter_write_sel) : 4'b0000;

    rice_csr_split_counter #(.XLEN(XLEN), .SPLIT_CARRY(SPLIT_CARRY)) u_cycle (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .i_up         (w_cy_up),
        .i_write_low  (w_wr[SEL_MCYCLE]),
        .i_write_high (w_wr[SEL_MCYCLEH]),
        .i_write_data (bus.i_counter_write_data),
        .o_low        (bus.o_cycle),
        .o_high       (bus.o_cycleh)
    );

    rice_csr_split_counter #(.XLEN(XLEN), .SPLIT_CARRY(SPLIT_CARRY)) u_instret (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .i_up         (w_ir_up),
        .i_write_low  (w_wr[SEL_MINSTRET]),
        .i_write_high (w_wr[SEL_MINSTRETH]),
        .i_write_data (bus.i_counter_write_data),
        .o_low        (bus.o_instret),
        .o_high       (bus.o_instreth)
    );

    assign bus.o_cycle_read_enable   = read_en(bus.i_privilege_level, bus.i_mcounteren[RICE_COUNTER_CY],
                                               bus.i_scounteren[RICE_COUNTER_CY]);
    assign bus.o_instret_read_enable = read_en(bus.i_privilege_level, bus.i_mcounteren[RICE_COUNTER_IR],
                                               bus.i_scounteren[RICE_COUNTER_IR]);
    assign bus.o_write_enable        = 1'b0;
endmodule

// File: tb/tb_rice_csr_counter_ctrl.sv
// tb_rice_csr_counter_ctrl: split-carry and single-cycle variants run side by side against a 64-bit value model.
module tb_rice_csr_counter_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  priv, mce, sce, inh, sel;
    logic        ret, wv;
    logic [31:0] wd;
    int checks = 0;
    int failures = 0;
    // Model state per variant (index = SPLIT_CARRY): {carry still in flight, true 64-bit count}.
    logic [64:0] m_cy [2];
    logic [64:0] m_ir [2];

    rice_csr_counter_ctrl_if b1 ();
    rice_csr_counter_ctrl_if b0 ();
    rice_csr_counter_ctrl #(.SPLIT_CARRY(1'b1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
    rice_csr_counter_ctrl #(.SPLIT_CARRY(1'b0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));

    assign b1.i_privilege_level = priv;
    assign b1.i_mcounteren = mce;
    assign b1.i_scounteren = sce;
    assign b1.i_mcountinhibit = inh;
    assign b1.i_retire = ret;
    assign b1.i_counter_write_valid = wv;
    assign b1.i_counter_write_sel = sel;
    assign b1.i_counter_write_data = wd;
    assign b0.i_privilege_level = priv;
    assign b0.i_mcounteren = mce;
    assign b0.i_scounteren = sce;
    assign b0.i_mcountinhibit = inh;
    assign b0.i_retire = ret;
    assign b0.i_counter_write_valid = wv;
    assign b0.i_counter_write_sel = sel;
    assign b0.i_counter_write_data = wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] mstep(input int split, input logic [64:0] st, input logic up,
                                          input logic wl, input logic wh, input logic [31:0] d);
        logic [63:0] v;
        logic wrap;
        v = st[63:0];
        wrap = up & ~wl & (v[31:0] == 32'hFFFF_FFFF);
        if (wl) return {1'b0, v[63:32], d};
        if (wh) return {(split != 0) ? wrap : 1'b0, d + ((split != 0) ? {31'b0, wrap} : 32'b0),
                        v[31:0] + {31'b0, up}};
        return {(split != 0) ? wrap : 1'b0, v + {63'b0, up}};
    endfunction

    function automatic logic [31:0] shown_hi(input logic [64:0] st);
        return st[63:32] - {31'b0, st[64]};
    endfunction

    function automatic logic ren(input logic [1:0] p, input logic m, input logic s);
        case (p)
            2'd3: return 1'b1;
            2'd1: return m;
            2'd0: return m & s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        chk("cycle_s1", b1.o_cycle, m_cy[1][31:0]);
        chk("cycleh_s1", b1.o_cycleh, shown_hi(m_cy[1]));
        chk("instret_s1", b1.o_instret, m_ir[1][31:0]);
        chk("instreth_s1", b1.o_instreth, shown_hi(m_ir[1]));
        chk("cycle_s0", b0.o_cycle, m_cy[0][31:0]);
        chk("cycleh_s0", b0.o_cycleh, shown_hi(m_cy[0]));
        chk("instret_s0", b0.o_instret, m_ir[0][31:0]);
        chk("instreth_s0", b0.o_instreth, shown_hi(m_ir[0]));
        chk("cy_ren", b1.o_cycle_read_enable, ren(priv, mce[0], sce[0]));
        chk("ir_ren", b1.o_instret_read_enable, ren(priv, mce[1], sce[1]));
        chk("wen", b1.o_write_enable | b0.o_write_enable, 0);
    endtask

    task automatic step();
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                m_cy[s] = '0;
                m_ir[s] = '0;
            end else begin
                m_cy[s] = mstep(s, m_cy[s], ~inh[0], wv && sel == 2'd0, wv && sel == 2'd2, wd);
                m_ir[s] = mstep(s, m_ir[s], ret & ~inh[1], wv && sel == 2'd1, wv && sel == 2'd3, wd);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        priv = 2'd3; mce = 2'b00; sce = 2'b00; inh = 2'b00;
        ret = 1'b0; wv = 1'b0; sel = 2'd0; wd = '0;
        m_cy[0] = '0; m_cy[1] = '0; m_ir[0] = '0; m_ir[1] = '0;
        rst_n = 1'b0;
        step();
        chk("rst_cycle", b1.o_cycle, 0);
        rst_n = 1'b1;
        repeat (5) step();
        chk("five_cycle", b1.o_cycle, 5);
        chk("five_cycleh", b1.o_cycleh, 0);
        chk("five_instret", b1.o_instret, 0);
        // Low-half wrap: split variant shows the old high for one extra cycle.
        wv = 1'b1; sel = 2'd2; wd = 32'h0;
        step();
        sel = 2'd0; wd = 32'hFFFF_FFFE;
        step();
        chk("wr_low", b1.o_cycle, 32'hFFFF_FFFE);
        wv = 1'b0;
        step();
        chk("pre_wrap", b1.o_cycle, 32'hFFFF_FFFF);
        step();
        chk("wrap_low", b1.o_cycle, 0);
        chk("wrap_skew_hi", b1.o_cycleh, 0);
        chk("wrap_nosplit_hi", b0.o_cycleh, 1);
        step();
        chk("wrap_late_hi", b1.o_cycleh, 1);
        // Write beats a same-cycle retire, then inhibit freezes instret.
        ret = 1'b1; wv = 1'b1; sel = 2'd1; wd = 32'h100;
        step();
        chk("ir_write_wins", b1.o_instret, 32'h100);
        wv = 1'b0; inh = 2'b10;
        repeat (2) step();
        chk("ir_inhibit", b1.o_instret, 32'h100);
        ret = 1'b0; inh = 2'b00;
        // A high write discards a pending carry.
        wv = 1'b1; sel = 2'd0; wd = 32'hFFFF_FFFF;
        step();
        wv = 1'b0;
        step();
        wv = 1'b1; sel = 2'd2; wd = 32'h55;
        step();
        wv = 1'b0;
        step();
        chk("carry_drop", b1.o_cycleh, 32'h55);
        chk("carry_drop_s0", b0.o_cycleh, 32'h55);
        // Privilege gating.
        priv = 2'd0; mce = 2'b11; sce = 2'b01;
        step();
        chk("u_cy_ren", b1.o_cycle_read_enable, 1);
        chk("u_ir_ren", b1.o_instret_read_enable, 0);
        priv = 2'd1;
        step();
        chk("s_ir_ren", b1.o_instret_read_enable, 1);
        priv = 2'd2;
        step();
        chk("rsv_ren", b1.o_cycle_read_enable, 0);
        // Reset with a carry in flight must not leak into high.
        wv = 1'b1; sel = 2'd0; wd = 32'hFFFF_FFFF;
        step();
        wv = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_lo", b1.o_cycle, 0);
        chk("rst_mid_hi", b1.o_cycleh, 0);
        rst_n = 1'b1;
        step();
        chk("rst_no_late_carry", b1.o_cycleh, 0);
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom % 80) != 0;
            priv = 2'($urandom);
            mce = 2'($urandom);
            sce = 2'($urandom);
            inh = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
            ret = 1'($urandom);
            wv = ($urandom % 5) == 0;
            sel = 2'($urandom);
            wd = ($urandom % 2 == 0) ? $urandom : (32'hFFFF_FFF8 | 32'($urandom % 8));
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
